// File: rtl/zelda_pkg.sv
// rtl/zelda_pkg.sv - shared direction codes, pixel field widths and scheduler states
package zelda_pkg;

  typedef enum logic [1:0] {
    UP    = 2'b00,
    DOWN  = 2'b01,
    LEFT  = 2'b10,
    RIGHT = 2'b11
  } dir_e;

  localparam logic ON  = 1'b1;
  localparam logic OFF = 1'b0;

  localparam int X_W = 9;
  localparam int Y_W = 8;
  localparam int C_W = 6;

  typedef enum logic [2:0] {
    S_INIT,
    S_WAIT_FRAME,
    S_WAIT_MAP,
    S_MOVE,
    S_DRAW,
    S_NEXT,
    S_DONE
  } sched_state_e;

endpackage

// File: rtl/sprite_draw_scheduler_if.sv
// rtl/sprite_draw_scheduler_if.sv - frame control, sprite drawer and VGA port bundle of the scheduler
interface sprite_draw_scheduler_if
  import zelda_pkg::*;
#(
  parameter int N_SPR = 4
);
  logic                   frame_tick;
  logic                   map_done;
  logic [N_SPR-1:0]       spr_active;
  logic [N_SPR-1:0]       dir_valid;
  logic [2*N_SPR-1:0]     dir;
  logic [N_SPR-1:0]       init;
  logic [N_SPR-1:0]       move_up;
  logic [N_SPR-1:0]       move_down;
  logic [N_SPR-1:0]       move_left;
  logic [N_SPR-1:0]       move_right;
  logic [N_SPR-1:0]       draw_char;
  logic [N_SPR-1:0]       draw_done;
  logic [X_W*N_SPR-1:0]   spr_x;
  logic [Y_W*N_SPR-1:0]   spr_y;
  logic [C_W*N_SPR-1:0]   spr_colour;
  logic [N_SPR-1:0]       spr_write;
  logic [X_W-1:0]         vga_x;
  logic [Y_W-1:0]         vga_y;
  logic [C_W-1:0]         vga_colour;
  logic                   vga_write;
  logic                   busy;
  logic                   frame_done;
  logic                   timeout_err;
  logic [7:0]             overrun_cnt;

  modport master (
    output frame_tick, map_done, spr_active, dir_valid, dir, draw_done,
           spr_x, spr_y, spr_colour, spr_write,
    input  init, move_up, move_down, move_left, move_right, draw_char,
           vga_x, vga_y, vga_colour, vga_write, busy, frame_done, timeout_err, overrun_cnt
  );

  modport slave (
    input  frame_tick, map_done, spr_active, dir_valid, dir, draw_done,
           spr_x, spr_y, spr_colour, spr_write,
    output init, move_up, move_down, move_left, move_right, draw_char,
           vga_x, vga_y, vga_colour, vga_write, busy, frame_done, timeout_err, overrun_cnt
  );

endinterface

// File: rtl/next_active_sel.sv
// rtl/next_active_sel.sv - picks the lowest set bit of active at or above start, with a found flag
module next_active_sel #(
  parameter int N  = 4,
  parameter int IW = 2
) (
  input  logic [N-1:0]  active,
  input  logic [IW:0]   start,
  output logic [IW-1:0] sel,
  output logic          found
);

  // Descending scan so the lowest qualifying index is the last one written.
  always_comb begin
    sel   = '0;
    found = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      if (active[i] && ((IW+1)'(i) >= start)) begin
        sel   = IW'(i);
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/sprite_draw_scheduler.sv
// rtl/sprite_draw_scheduler.sv - per-frame move/draw sequencer sharing one VGA write port among sprite drawers
// Optional feature: define DRAW_SCHED_STATS_EN to build the saturating dropped-tick counter on overrun_cnt.
module sprite_draw_scheduler
  import zelda_pkg::*;
#(
  parameter int N_SPR   = 4,
  parameter int TIMEOUT = 512,
  parameter int TW      = 10
) (
  input  logic                   clock,
  input  logic                   reset,
  sprite_draw_scheduler_if.slave bus
);

  localparam int IW = (N_SPR > 1) ? $clog2(N_SPR) : 1;

  sched_state_e     state;
  logic [IW-1:0]    grant;
  logic             pending;
  logic [TW-1:0]    cnt;
  logic [N_SPR-1:0] init_q, up_q, down_q, left_q, right_q, draw_q;
  logic             busy_q, frame_done_q, timeout_q;
  logic [IW:0]      sel_start;
  logic [IW-1:0]    sel;
  logic             sel_found;

  assign sel_start = (state == S_NEXT) ? ({1'b0, grant} + (IW+1)'(1)) : '0;

  next_active_sel #(.N(N_SPR), .IW(IW)) u_sel (
    .active (bus.spr_active),
    .start  (sel_start),
    .sel    (sel),
    .found  (sel_found)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state        <= S_INIT;
      grant        <= '0;
      pending      <= OFF;
      cnt          <= '0;
      init_q       <= '0;
      up_q         <= '0;
      down_q       <= '0;
      left_q       <= '0;
      right_q      <= '0;
      draw_q       <= '0;
      busy_q       <= OFF;
      frame_done_q <= OFF;
      timeout_q    <= OFF;
    end else begin
      init_q       <= '0;
      up_q         <= '0;
      down_q       <= '0;
      left_q       <= '0;
      right_q      <= '0;
      frame_done_q <= OFF;
      // Ticks arriving outside S_WAIT_FRAME, including the S_DONE exit cycle, are remembered.
      if (state != S_WAIT_FRAME && bus.frame_tick) pending <= ON;
      case (state)
        S_INIT: begin
          init_q <= '1;
          state  <= S_WAIT_FRAME;
        end
        S_WAIT_FRAME: begin
          if (bus.frame_tick || pending) begin
            pending <= OFF;
            busy_q  <= ON;
            state   <= S_WAIT_MAP;
          end
        end
        S_WAIT_MAP: begin
          if (bus.map_done) begin
            if (bus.spr_active == '0) begin
              frame_done_q <= ON;
              state        <= S_DONE;
            end else begin
              state <= S_MOVE;
            end
          end
        end
        S_MOVE, S_NEXT: begin
          if (state == S_MOVE) begin
            for (int i = 0; i < N_SPR; i++) begin
              if (bus.spr_active[i] && bus.dir_valid[i]) begin
                case (dir_e'(bus.dir[2*i +: 2]))
                  UP:      up_q[i]    <= ON;
                  DOWN:    down_q[i]  <= ON;
                  LEFT:    left_q[i]  <= ON;
                  default: right_q[i] <= ON;
                endcase
              end
            end
          end
          if (sel_found) begin
            grant  <= sel;
            draw_q <= N_SPR'(1) << sel;
            cnt    <= '0;
            state  <= S_DRAW;
          end else begin
            frame_done_q <= ON;
            state        <= S_DONE;
          end
        end
        S_DRAW: begin
          cnt <= cnt + TW'(1);
          if (bus.draw_done[grant]) begin
            draw_q <= '0;
            state  <= S_NEXT;
          end else if (cnt == TW'(TIMEOUT - 1)) begin
            timeout_q <= ON;
            draw_q    <= '0;
            state     <= S_NEXT;
          end
        end
        S_DONE: begin
          busy_q <= OFF;
          state  <= S_WAIT_FRAME;
        end
        default: state <= S_INIT;
      endcase
    end
  end

`ifdef DRAW_SCHED_STATS_EN
  logic [7:0] overrun_q;
  logic       tick_drop;

  assign tick_drop = bus.frame_tick && pending && (state != S_WAIT_FRAME);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      overrun_q <= '0;
    end else if (tick_drop && overrun_q != 8'hFF) begin
      overrun_q <= overrun_q + 8'd1;
    end
  end

  assign bus.overrun_cnt = overrun_q;
`else
  assign bus.overrun_cnt = '0;
`endif

  always_comb begin
    bus.vga_x      = '0;
    bus.vga_y      = '0;
    bus.vga_colour = '0;
    bus.vga_write  = OFF;
    if (state == S_DRAW) begin
      bus.vga_x      = bus.spr_x[grant*X_W +: X_W];
      bus.vga_y      = bus.spr_y[grant*Y_W +: Y_W];
      bus.vga_colour = bus.spr_colour[grant*C_W +: C_W];
      bus.vga_write  = bus.spr_write[grant];
    end
  end

  assign bus.init        = init_q;
  assign bus.move_up     = up_q;
  assign bus.move_down   = down_q;
  assign bus.move_left   = left_q;
  assign bus.move_right  = right_q;
  assign bus.draw_char   = draw_q;
  assign bus.busy        = busy_q;
  assign bus.frame_done  = frame_done_q;
  assign bus.timeout_err = timeout_q;

endmodule

// File: tb/tb_sprite_draw_scheduler.sv
// tb/tb_sprite_draw_scheduler.sv - scoreboard bench for sprite_draw_scheduler (grant order, moves, timeout, overrun, reset)
module tb_sprite_draw_scheduler;
  import zelda_pkg::*;

  localparam int N       = 4;
  localparam int TIMEOUT = 512;
`ifdef DRAW_SCHED_STATS_EN
  localparam int EXP_OVR = 1;
`else
  localparam int EXP_OVR = 0;
`endif

  logic clock = 1'b0;
  logic reset = 1'b0;
  int   checks = 0;
  int   errors = 0;
  int   exp_q[$];
  int   glen [N];
  int   dcnt [N];
  int   mv_cycles;
  int   frames;
  logic [N-1:0] mv_up, mv_dn, mv_lf, mv_rt;

  sprite_draw_scheduler_if #(.N_SPR(N)) bus ();

  sprite_draw_scheduler #(.N_SPR(N), .TIMEOUT(TIMEOUT), .TW(10)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  function automatic logic others_on();
    return (|bus.move_up) | (|bus.move_down) | (|bus.move_left) | (|bus.move_right) |
           (|bus.draw_char) | (|bus.vga_x) | (|bus.vga_y) | (|bus.vga_colour) | bus.vga_write |
           bus.busy | bus.frame_done | bus.timeout_err | (|bus.overrun_cnt);
  endfunction

  function automatic logic any_out();
    return (|bus.init) | others_on();
  endfunction

  task automatic clear_inputs();
    bus.frame_tick = 1'b0;
    bus.map_done   = 1'b0;
    bus.spr_active = '0;
    bus.dir_valid  = '0;
    bus.dir        = '0;
    bus.draw_done  = '0;
    bus.spr_x      = '0;
    bus.spr_y      = '0;
    bus.spr_colour = '0;
    bus.spr_write  = '0;
    for (int i = 0; i < N; i++) dcnt[i] = 0;
  endtask

  task automatic drive_drawers(input logic [N-1:0] hang, input int lat);
    logic [N-1:0]     done_v, wr_v;
    logic [X_W*N-1:0] xv;
    logic [Y_W*N-1:0] yv;
    logic [C_W*N-1:0] cv;
    for (int i = 0; i < N; i++) begin
      if (bus.draw_char[i]) dcnt[i]++;
      else dcnt[i] = 0;
      done_v[i] = bus.draw_char[i] && !hang[i] && (dcnt[i] >= lat);
      wr_v[i]   = bus.draw_char[i] && !done_v[i];
      xv[i*X_W +: X_W] = X_W'(i*40 + dcnt[i]);
      yv[i*Y_W +: Y_W] = Y_W'(i*20 + dcnt[i]);
      cv[i*C_W +: C_W] = C_W'(i*3 + 1 + dcnt[i]);
    end
    bus.draw_done  = done_v;
    bus.spr_write  = wr_v;
    bus.spr_x      = xv;
    bus.spr_y      = yv;
    bus.spr_colour = cv;
  endtask

  task automatic count_init(input string name, input int ncyc);
    int init_cycles;
    logic bad;
    init_cycles = 0;
    bad = 1'b0;
    repeat (ncyc) begin
      @(negedge clock);
      if (bus.init === {N{1'b1}}) init_cycles++;
      else if (bus.init !== '0) bad = 1'b1;
      if (others_on() !== 1'b0) bad = 1'b1;
    end
    checks++;
    if (init_cycles != 1) begin
      errors++;
      $display("FAIL %s init_pulse: saw %0d all-ones cycles, required 1", name, init_cycles);
    end
    checks++;
    if (bad !== 1'b0) begin
      errors++;
      $display("FAIL %s idle_outputs: got nonzero output, required all 0", name);
    end
  endtask

  task automatic run_frames(input string name, input logic [N-1:0] act, input logic [N-1:0] hang,
                            input int lat, input int extra_ticks, input int exp_frames);
    logic [N-1:0] prev, dc;
    int g, pg, e, cyc, ticks_left, exp_len;
    exp_q.delete();
    for (int f = 0; f < exp_frames; f++)
      for (int i = 0; i < N; i++)
        if (act[i]) exp_q.push_back(i);
    frames = 0; mv_cycles = 0; prev = '0; pg = 0; ticks_left = extra_ticks;
    mv_up = '0; mv_dn = '0; mv_lf = '0; mv_rt = '0;
    bus.spr_active = act;
    bus.map_done   = 1'b0;
    @(negedge clock); bus.frame_tick = 1'b1;
    @(negedge clock); bus.frame_tick = 1'b0;
    cyc = 0;
    while (frames < exp_frames && cyc < 6000) begin
      @(negedge clock);
      cyc++;
      dc = bus.draw_char;
      if (cyc == 5) begin
        checks++;
        if (dc !== '0 || bus.busy !== 1'b1) begin
          errors++;
          $display("FAIL %s map_wait: draw_char=%b busy=%b, required 0000 and 1", name, dc, bus.busy);
        end
        bus.map_done = 1'b1;
      end
      if (dc != '0 && dc != prev) begin
        g = 0;
        for (int i = N - 1; i >= 0; i--) if (dc[i]) g = i;
        checks++;
        if (prev !== '0 || $countones(dc) != 1 || bus.busy !== 1'b1) begin
          errors++;
          $display("FAIL %s grant_gap: prev=%b now=%b busy=%b, required prev 0, one-hot, busy 1", name, prev, dc, bus.busy);
        end
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL %s grant_order: got sprite %0d, required no further grant", name, g);
        end else begin
          e = exp_q.pop_front();
          if (g != e) begin
            errors++;
            $display("FAIL %s grant_order: got sprite %0d, required %0d", name, g, e);
          end
        end
        glen[g] = 0;
        pg = g;
      end
      if (dc != '0) begin
        glen[pg]++;
        if (glen[pg] == 3) begin
          checks++;
          if (bus.vga_x !== X_W'(pg*40 + 2) || bus.vga_y !== Y_W'(pg*20 + 2) ||
              bus.vga_colour !== C_W'(pg*3 + 3) || bus.vga_write !== 1'b1) begin
            errors++;
            $display("FAIL %s vga_mux: sprite %0d got x=%0d y=%0d c=%0d w=%b, required x=%0d y=%0d c=%0d w=1",
                     name, pg, bus.vga_x, bus.vga_y, bus.vga_colour, bus.vga_write, pg*40 + 2, pg*20 + 2, pg*3 + 3);
          end
        end
      end else if (prev != '0) begin
        exp_len = hang[pg] ? TIMEOUT : lat;
        checks++;
        if (glen[pg] != exp_len) begin
          errors++;
          $display("FAIL %s grant_len: sprite %0d held %0d cycles, required %0d", name, pg, glen[pg], exp_len);
        end
      end
      if ((bus.move_up | bus.move_down | bus.move_left | bus.move_right) != '0) begin
        mv_cycles++;
        mv_up = bus.move_up; mv_dn = bus.move_down; mv_lf = bus.move_left; mv_rt = bus.move_right;
      end
      if (bus.frame_done) frames++;
      if (ticks_left > 0 && cyc >= 20 && cyc % 10 == 0) begin
        bus.frame_tick = 1'b1;
        ticks_left--;
      end else begin
        bus.frame_tick = 1'b0;
      end
      prev = dc;
      drive_drawers(hang, lat);
    end
    bus.frame_tick = 1'b0;
    checks++;
    if (frames != exp_frames) begin
      errors++;
      $display("FAIL %s frame_count: got %0d frame_done pulses, required %0d", name, frames, exp_frames);
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s missing_grants: %0d grants outstanding, required 0", name, exp_q.size());
    end
    repeat (2) begin
      @(negedge clock);
      drive_drawers(hang, lat);
    end
    checks++;
    if (bus.busy !== 1'b0 || bus.draw_char !== '0) begin
      errors++;
      $display("FAIL %s idle_after: busy=%b draw_char=%b, required 0 and 0000", name, bus.busy, bus.draw_char);
    end
  endtask

  task automatic test_reset();
    clear_inputs();
    reset = 1'b0;
    repeat (3) @(negedge clock);
    checks++;
    if (any_out() !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: got nonzero output, required all 0");
    end
    reset = 1'b1;
    count_init("reset", 10);
  endtask

  task automatic test_order();
    run_frames("order", 4'b1011, 4'b0000, 256, 0, 1);
    checks++;
    if (bus.timeout_err !== 1'b0) begin
      errors++;
      $display("FAIL order timeout_err: got %b, required 0", bus.timeout_err);
    end
  endtask

  task automatic test_moves();
    bus.dir_valid = 4'b0101;
    bus.dir       = 8'b10_11_01_00;
    run_frames("moves", 4'b1111, 4'b0000, 8, 0, 1);
    bus.dir_valid = '0;
    checks++;
    if (mv_cycles != 1) begin
      errors++;
      $display("FAIL moves pulse_cycles: got %0d, required 1", mv_cycles);
    end
    checks++;
    if ({mv_up, mv_dn, mv_lf, mv_rt} !== {4'b0001, 4'b0000, 4'b0000, 4'b0100}) begin
      errors++;
      $display("FAIL moves bits: up=%b down=%b left=%b right=%b, required 0001 0000 0000 0100",
               mv_up, mv_dn, mv_lf, mv_rt);
    end
  endtask

  task automatic test_empty();
    run_frames("empty", 4'b0000, 4'b0000, 8, 0, 1);
  endtask

  task automatic test_timeout();
    run_frames("timeout", 4'b1011, 4'b0010, 64, 0, 1);
    checks++;
    if (bus.timeout_err !== 1'b1) begin
      errors++;
      $display("FAIL timeout flag: got %b, required 1", bus.timeout_err);
    end
    run_frames("timeout_after", 4'b1011, 4'b0000, 16, 0, 1);
    checks++;
    if (bus.timeout_err !== 1'b1) begin
      errors++;
      $display("FAIL timeout sticky: got %b, required 1", bus.timeout_err);
    end
  endtask

  task automatic test_overrun();
    run_frames("overrun", 4'b1011, 4'b0000, 16, 2, 2);
    checks++;
    if (bus.overrun_cnt !== 8'(EXP_OVR)) begin
      errors++;
      $display("FAIL overrun count: got %0d, required %0d", bus.overrun_cnt, EXP_OVR);
    end
  endtask

  task automatic test_reset_mid_draw();
    int cyc;
    bus.spr_active = 4'b1111;
    bus.map_done   = 1'b1;
    @(negedge clock); bus.frame_tick = 1'b1;
    @(negedge clock); bus.frame_tick = 1'b0;
    cyc = 0;
    while (bus.draw_char == '0 && cyc < 50) begin
      @(negedge clock);
      cyc++;
    end
    checks++;
    if (bus.draw_char == '0) begin
      errors++;
      $display("FAIL mid_draw reach: draw_char=%b after %0d cycles, required a grant", bus.draw_char, cyc);
    end
    #2 reset = 1'b0;
    #1;
    checks++;
    if (any_out() !== 1'b0) begin
      errors++;
      $display("FAIL mid_draw async_clear: got nonzero output, required all 0");
    end
    clear_inputs();
    @(negedge clock);
    reset = 1'b1;
    count_init("mid_draw", 5);
  endtask

  initial begin
    clear_inputs();
    test_reset();
    test_order();
    test_moves();
    test_empty();
    test_timeout();
    test_overrun();
    test_reset_mid_draw();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
